add_mul_result_acc: RTL and testbench
=====================================

Name: add_mul_result_acc

Overview:
- Downstream consumer of the 4-bit add/multiply unit; accepts its 8-bit result plus the operation tag through a valid/ready handshake.
- Buffers results in a small FIFO and sums consecutive same-mode results into groups of GROUP entries, saturating at ACC_W bits.
- Presents each completed group sum, mode, entry count and overflow flag on an output valid/ready port to the next stage.

Parameters:
- DEPTH, 4, input FIFO entries (power of two, >=2).
- GROUP, 4, results per group before a sum is emitted (2..255).
- ACC_W, 10, accumulator and out_data width (>=8).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush of FIFO, accumulator and output register.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  FIFO can accept this cycle.
- in_result  input  8  unsigned result from the add/mul unit.
- in_operation  input  1  mode tag: 1 = multiply, 0 = add.
- out_valid  output  1  group sum valid.
- out_ready  input  1  downstream accepts.
- out_data  output  ACC_W  saturated group sum.
- out_mode  output  1  mode of the group.
- out_count  output  8  number of results in the group (1..GROUP).
- out_overflow  output  1  saturation occurred within the group.

Behaviour:
- Reset (rst_n=0, async): FIFO empty, state IDLE, acc=0, cnt=0, mode=0, all out_* = 0, in_ready = 0 while rst_n is low, then 1.
- in_ready = !full, from registered occupancy only. Push when in_valid & in_ready. FIFO data width is 9 bits (result + tag).
- Push and pop in the same cycle are both allowed when the FIFO is not full. When the FIFO is full, in_ready=0, even if a pop occurs that cycle.
- Latency: an item pushed at edge t is at the FIFO head after t and is consumed at edge t+1 at the earliest. A group of GROUP results fed back-to-back with an idle output gives out_valid high one cycle after the last consume.
- FSM states: IDLE, ACC, EMIT.
  - IDLE: if head valid, pop; acc = zero-extended head; cnt = 1; mode = head tag; ovf = 0. Go to ACC, or to EMIT if GROUP==1.
  - ACC, head tag == mode: pop; acc = min(acc + head, 2^ACC_W-1); ovf |= carry-out/saturate; cnt++. If cnt reaches GROUP, go to EMIT.
  - ACC, head tag != mode: no pop; go to EMIT with the partial group (early flush). That item starts the next group.
  - ACC, FIFO empty: hold with no timeout.
  - EMIT: out_valid=1 and out_* are stable. No pop occurs while in EMIT. On out_valid & out_ready, go to IDLE, clear acc/cnt/ovf, and drop out_valid on the next cycle.
- Output signals are registered. out_data/out_mode/out_count/out_overflow must not change while out_valid=1 and out_ready=0.
- Saturation: the sum is computed in ACC_W+1 bits. If the top bit is set, acc = all-ones and ovf = 1. Once saturated, acc stays at all-ones.
- clear (sync) has priority over all other activity in its cycle:
  - FIFO emptied, state IDLE, out_valid=0, acc/cnt/ovf=0.
  - A push presented in the same cycle is discarded. in_ready is unaffected by clear.
- Reset asserted mid-group or in EMIT: immediate return to reset values; no partial output is emitted.
- All arithmetic is unsigned; in_result is never sign-extended.

Test Plan:
- Defaults; push mul results 225,225,225,225 back-to-back with out_ready=1 -> one output: data=900, mode=1, count=4, overflow=0; out_valid high for exactly 1 cycle.
- Push add 3, add 5, then mul 6, mul 6 -> first output data=8, mode=0, count=2; the mul group stays pending (count 2) until two more mul entries arrive.
- GROUP=8; push eight results of 255 (mode 1) -> data=1023, overflow=1, count=8.
- Hold out_ready=0 while pushing 8 more results -> in_ready drops to 0 after DEPTH entries are buffered. out_* stay stable throughout. Release out_ready -> all queued data drains with no loss or duplication.
- Assert clear with 2 results accumulated and 1 result in the FIFO -> next cycle out_valid=0, FIFO empty; a fresh add 7 x4 yields data=28, count=4.
- Pulse rst_n low while in EMIT with out_ready=0 -> out_valid=0 asynchronously; all outputs 0; subsequent group behaves as from power-up.

Source files
------------

// File: rtl/add_mul_result_acc_if.sv
// add_mul_result_acc_if: result-in / group-sum-out handshake bundle for add_mul_result_acc
interface add_mul_result_acc_if #(parameter int ACC_W = 10);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_result;
  logic             in_operation;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_mode;
  logic [7:0]       out_count;
  logic             out_overflow;
  modport master (
    output in_valid, in_result, in_operation, out_ready,
    input  in_ready, out_valid, out_data, out_mode, out_count, out_overflow
  );
  modport slave (
    input  in_valid, in_result, in_operation, out_ready,
    output in_ready, out_valid, out_data, out_mode, out_count, out_overflow
  );
endinterface

// File: rtl/add_mul_result_acc.sv
// add_mul_result_acc: FIFO-buffered grouping of same-mode add/mul results into saturating sums
module add_mul_result_acc #(
  parameter int DEPTH = 4,
  parameter int GROUP = 4,
  parameter int ACC_W = 10
) (
  input logic clk,
  input logic rst_n,
  input logic clear,
  add_mul_result_acc_if.slave io
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ACC, EMIT} state_t;
  logic [8:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      fcnt_q, fcnt_d;
  logic             rdy_q, rdy_d;
  logic             push, pop, head_v;
  logic [8:0]       head;
  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             mode_q, mode_d, ovf_q, ovf_d;
  logic [ACC_W:0]   sum;
  logic             out_valid_q, out_valid_d, out_mode_q, out_mode_d, out_ovf_q, out_ovf_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic [7:0]       out_count_q, out_count_d;
  logic             load;
  assign head   = mem_q[rd_q];
  assign head_v = fcnt_q != '0;
  assign push   = io.in_valid & rdy_q & ~clear;
  assign sum    = {1'b0, acc_q} + (ACC_W+1)'(head[7:0]);
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    ovf_d   = ovf_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (head_v) begin
        pop     = 1'b1;
        acc_d   = ACC_W'(head[7:0]);
        cnt_d   = 8'd1;
        mode_d  = head[8];
        ovf_d   = 1'b0;
        state_d = (GROUP == 1) ? EMIT : ACC;
      end
      ACC: if (head_v) begin
        // a mode change closes the group early; the mismatching item stays queued
        if (head[8] == mode_q) begin
          pop     = 1'b1;
          acc_d   = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
          ovf_d   = ovf_q | sum[ACC_W];
          cnt_d   = cnt_q + 8'd1;
          state_d = (cnt_d == 8'(GROUP)) ? EMIT : ACC;
        end else state_d = EMIT;
      end
      default: if (io.out_ready) begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
    endcase
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      pop     = 1'b0;
    end
  end
  always_comb begin
    wr_d   = clear ? '0 : push ? wr_q + 1'b1 : wr_q;
    rd_d   = clear ? '0 : pop  ? rd_q + 1'b1 : rd_q;
    fcnt_d = clear ? '0 : fcnt_q + (AW+1)'(push) - (AW+1)'(pop);
    rdy_d  = fcnt_d != (AW+1)'(DEPTH);
  end
  // output bundle is captured once on entry to EMIT so it holds under backpressure
  assign load = (state_d == EMIT) && (state_q != EMIT);
  always_comb begin
    out_valid_d = state_d == EMIT;
    out_data_d  = load ? acc_d  : out_data_q;
    out_mode_d  = load ? mode_d : out_mode_q;
    out_count_d = load ? cnt_d  : out_count_q;
    out_ovf_d   = load ? ovf_d  : out_ovf_q;
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= {io.in_operation, io.in_result};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q        <= '0;
      rd_q        <= '0;
      fcnt_q      <= '0;
      rdy_q       <= 1'b0;
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mode_q  <= 1'b0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      fcnt_q      <= fcnt_d;
      rdy_q       <= rdy_d;
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_mode_q  <= out_mode_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  assign io.in_ready     = rdy_q;
  assign io.out_valid    = out_valid_q;
  assign io.out_data     = out_data_q;
  assign io.out_mode     = out_mode_q;
  assign io.out_count    = out_count_q;
  assign io.out_overflow = out_ovf_q;
endmodule

// File: tb/tb_add_mul_result_acc.sv
// tb_add_mul_result_acc: directed checks of grouping, saturation, backpressure, clear and reset
module tb_add_mul_result_acc;
  typedef struct packed {
    logic [9:0] d;
    logic       m;
    logic [7:0] c;
    logic       o;
  } rec_t;
  logic clk = 1'b0;
  logic rst_n, clear;
  int total = 0, passed = 0, vc4 = 0;
  rec_t q4[$], q8[$];
  add_mul_result_acc_if #(.ACC_W(10)) b4();
  add_mul_result_acc_if #(.ACC_W(10)) b8();
  add_mul_result_acc #(.DEPTH(4), .GROUP(4), .ACC_W(10)) dut4 (.clk(clk), .rst_n(rst_n), .clear(clear), .io(b4));
  add_mul_result_acc #(.DEPTH(4), .GROUP(8), .ACC_W(10)) dut8 (.clk(clk), .rst_n(rst_n), .clear(clear), .io(b8));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (b4.out_valid) vc4++;
    if (b4.out_valid && b4.out_ready) q4.push_back({b4.out_data, b4.out_mode, b4.out_count, b4.out_overflow});
    if (b8.out_valid && b8.out_ready) q8.push_back({b8.out_data, b8.out_mode, b8.out_count, b8.out_overflow});
  end
  task automatic check(input string t, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%0d exp=%0d", t, got, exp);
    else passed++;
  endtask
  task automatic sync();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input bit s, input logic [7:0] r, input logic op);
    int n;
    n = 0;
    if (s) begin b8.in_valid = 1'b1; b8.in_result = r; b8.in_operation = op; end
    else   begin b4.in_valid = 1'b1; b4.in_result = r; b4.in_operation = op; end
    @(negedge clk);
    while (!(s ? b8.in_ready : b4.in_ready) && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n == 100) check("push_timeout", 0, 1);
    sync();
    b4.in_valid = 1'b0;
    b8.in_valid = 1'b0;
  endtask
  task automatic expect_out(input bit s, input string t, input logic [9:0] d, input logic m,
                            input logic [7:0] c, input logic o);
    rec_t r;
    int n;
    n = 0;
    while ((s ? q8.size() : q4.size()) == 0 && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (n == 300) check({t, "_timeout"}, 0, 1);
    else begin
      if (s) r = q8.pop_front();
      else   r = q4.pop_front();
      check({t, "_data"}, 32'(r.d), 32'(d));
      check({t, "_mode"}, 32'(r.m), 32'(m));
      check({t, "_count"}, 32'(r.c), 32'(c));
      check({t, "_ovf"}, 32'(r.o), 32'(o));
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog total=%0d passed=%0d", total, passed);
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    b4.in_valid = 1'b0; b4.in_result = '0; b4.in_operation = 1'b0; b4.out_ready = 1'b1;
    b8.in_valid = 1'b0; b8.in_result = '0; b8.in_operation = 1'b0; b8.out_ready = 1'b1;
    #7;
    check("rst_in_ready", 32'(b4.in_ready), 0);
    check("rst_out_valid", 32'(b4.out_valid), 0);
    check("rst_out_data", 32'(b4.out_data), 0);
    check("rst_out_count", 32'(b4.out_count), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) sync();
    check("rdy_after_reset", 32'(b4.in_ready), 1);
    vc4 = 0;
    for (int i = 0; i < 4; i++) push(0, 8'd225, 1'b1);
    expect_out(0, "mul225", 10'd900, 1'b1, 8'd4, 1'b0);
    repeat (3) @(negedge clk);
    check("mul225_valid_cycles", 32'(vc4), 1);
    sync();
    push(0, 8'd3, 1'b0);
    push(0, 8'd5, 1'b0);
    push(0, 8'd6, 1'b1);
    push(0, 8'd6, 1'b1);
    expect_out(0, "add_flush", 10'd8, 1'b0, 8'd2, 1'b0);
    repeat (10) @(negedge clk);
    check("mul_pending_q", 32'(q4.size()), 0);
    check("mul_pending_valid", 32'(b4.out_valid), 0);
    sync();
    push(0, 8'd6, 1'b1);
    push(0, 8'd6, 1'b1);
    expect_out(0, "mul_rest", 10'd24, 1'b1, 8'd4, 1'b0);
    sync();
    for (int i = 0; i < 8; i++) push(1, 8'd255, 1'b1);
    expect_out(1, "sat", 10'd1023, 1'b1, 8'd8, 1'b1);
    sync();
    b4.out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(0, 8'(i), 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(b4.in_ready), 0);
      check("bp_valid", 32'(b4.out_valid), 1);
      check("bp_data", 32'(b4.out_data), 10);
      check("bp_count", 32'(b4.out_count), 4);
    end
    sync();
    b4.out_ready = 1'b1;
    expect_out(0, "drain1", 10'd10, 1'b0, 8'd4, 1'b0);
    expect_out(0, "drain2", 10'd26, 1'b0, 8'd4, 1'b0);
    repeat (10) @(negedge clk);
    check("drain_no_dup", 32'(q4.size()), 0);
    sync();
    push(0, 8'd1, 1'b0);
    push(0, 8'd2, 1'b0);
    push(0, 8'd3, 1'b0);
    clear = 1'b1;
    sync();
    clear = 1'b0;
    @(negedge clk);
    check("clr_valid", 32'(b4.out_valid), 0);
    check("clr_in_ready", 32'(b4.in_ready), 1);
    sync();
    for (int i = 0; i < 4; i++) push(0, 8'd7, 1'b0);
    expect_out(0, "post_clear", 10'd28, 1'b0, 8'd4, 1'b0);
    sync();
    b4.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(0, 8'd1, 1'b1);
    repeat (3) @(negedge clk);
    check("pre_rst_valid", 32'(b4.out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(b4.out_valid), 0);
    check("async_rst_data", 32'(b4.out_data), 0);
    check("async_rst_mode", 32'(b4.out_mode), 0);
    check("async_rst_count", 32'(b4.out_count), 0);
    check("async_rst_in_ready", 32'(b4.in_ready), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    b4.out_ready = 1'b1;
    repeat (2) sync();
    for (int i = 0; i < 4; i++) push(0, 8'd2, 1'b0);
    expect_out(0, "post_rst", 10'd8, 1'b0, 8'd4, 1'b0);
    repeat (5) @(negedge clk);
    check("post_rst_no_extra", 32'(q4.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
